// File: rtl/snn_pkg.sv
// snn_pkg: shared SNN types and helpers (decoder FSM encoding, saturating increment).
package snn_pkg;
  typedef enum logic [1:0] {DEC_IDLE, DEC_COUNT, DEC_ARGMAX, DEC_HOLD} dec_state_t;
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max);
    return (v == max) ? v : v + 32'd1;
  endfunction
endpackage

// File: rtl/spike_counter.sv
// spike_counter: single saturating spike counter with synchronous clear.
module spike_counter import snn_pkg::*; #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic         inc,
  output logic [W-1:0] count
);
  localparam logic [31:0] MAX = (W >= 32) ? '1 : (32'd1 << W) - 32'd1;
  always_ff @(posedge clk or negedge rst)
    if (!rst) count <= '0;
    else if (clr) count <= '0;
    else if (en && inc) count <= W'(sat_inc(32'(count), MAX));
endmodule

// File: rtl/spike_rate_decoder.sv
// spike_rate_decoder: windowed per-neuron spike counting with rate-coded winner.
// SPIKE_DECODER_ARGMAX_EN enables the sequential argmax scan; otherwise winner is 0.
module spike_rate_decoder import snn_pkg::*; #(
  parameter int NUM_OUTPUTS = 4,
  parameter int WINDOW      = 64,
  parameter int COUNT_WIDTH = 8,
  parameter int IDX_WIDTH   = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic [NUM_OUTPUTS-1:0]             spike_in,
  output logic                               busy,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [NUM_OUTPUTS*COUNT_WIDTH-1:0] counts,
  output logic [IDX_WIDTH-1:0]               winner,
  output logic                               no_spike
);
  localparam int TW = $clog2(WINDOW + 1);
  dec_state_t state;
  logic [TW-1:0] tcnt;
  logic [COUNT_WIDTH-1:0] cnt [NUM_OUTPUTS];
  logic clr, en, last_sample;
  assign clr = (state == DEC_IDLE) && start;
  assign en = state == DEC_COUNT;
  assign last_sample = tcnt == TW'(WINDOW - 1);
  for (genvar i = 0; i < NUM_OUTPUTS; i++) begin : g_cnt
    spike_counter #(.W(COUNT_WIDTH)) u_cnt (
      .clk  (clk),
      .rst  (rst),
      .clr  (clr),
      .en   (en),
      .inc  (spike_in[i]),
      .count(cnt[i])
    );
    assign counts[i*COUNT_WIDTH +: COUNT_WIDTH] = cnt[i];
  end
`ifdef SPIKE_DECODER_ARGMAX_EN
  logic [IDX_WIDTH-1:0] sidx, best_idx;
  logic [COUNT_WIDTH-1:0] best_cnt;
  logic gt;
  // strict compare keeps the lowest index on ties
  assign gt = cnt[sidx] > best_cnt;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= DEC_IDLE;
      tcnt <= '0;
      busy <= 1'b0;
      out_valid <= 1'b0;
      winner <= '0;
      no_spike <= 1'b0;
      sidx <= '0;
      best_idx <= '0;
      best_cnt <= '0;
    end else
      case (state)
        DEC_IDLE:
          if (start) begin
            state <= DEC_COUNT;
            tcnt <= '0;
            busy <= 1'b1;
            winner <= '0;
            no_spike <= 1'b0;
            sidx <= '0;
            best_idx <= '0;
            best_cnt <= '0;
          end
        DEC_COUNT: begin
          tcnt <= tcnt + TW'(1);
          if (last_sample) state <= DEC_ARGMAX;
        end
        DEC_ARGMAX: begin
          if (gt) begin
            best_cnt <= cnt[sidx];
            best_idx <= sidx;
          end
          sidx <= sidx + IDX_WIDTH'(1);
          if (sidx == IDX_WIDTH'(NUM_OUTPUTS - 1)) begin
            state <= DEC_HOLD;
            busy <= 1'b0;
            out_valid <= 1'b1;
            winner <= gt ? sidx : best_idx;
            no_spike <= ~|counts;
          end
        end
        default:
          if (out_ready) begin
            state <= DEC_IDLE;
            out_valid <= 1'b0;
          end
      endcase
`else
  logic done;
  assign winner = '0;
  // done marks that the counts hold a finished result, so no_spike stays 0 while counting
  assign no_spike = done && ~|counts;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= DEC_IDLE;
      tcnt <= '0;
      busy <= 1'b0;
      out_valid <= 1'b0;
      done <= 1'b0;
    end else
      case (state)
        DEC_IDLE:
          if (start) begin
            state <= DEC_COUNT;
            tcnt <= '0;
            busy <= 1'b1;
            done <= 1'b0;
          end
        DEC_COUNT: begin
          tcnt <= tcnt + TW'(1);
          if (last_sample) begin
            state <= DEC_HOLD;
            busy <= 1'b0;
            out_valid <= 1'b1;
            done <= 1'b1;
          end
        end
        DEC_HOLD:
          if (out_ready) begin
            state <= DEC_IDLE;
            out_valid <= 1'b0;
          end
        default: state <= DEC_IDLE;
      endcase
`endif
endmodule

// File: tb/tb_spike_rate_decoder.sv
// tb_spike_rate_decoder: two decoders (8-bit and 4-bit counters) driven in parallel, checked against a window model.
module tb_spike_rate_decoder;
  localparam int N = 4;
  localparam int WIN = 64;
`ifdef SPIKE_DECODER_ARGMAX_EN
  localparam int LAT = WIN + N;
  localparam bit ARGM = 1'b1;
`else
  localparam int LAT = WIN;
  localparam bit ARGM = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b0, start = 1'b0, out_ready = 1'b0;
  logic [N-1:0] spike_in = '0;
  logic busy0, valid0, ns0, busy1, valid1, ns1;
  logic [31:0] counts0;
  logic [15:0] counts1;
  logic [1:0] win0, win1;
  int checks = 0, failures = 0, cyc = 0, ks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  spike_rate_decoder #(.NUM_OUTPUTS(N), .WINDOW(WIN), .COUNT_WIDTH(8)) d0 (
    .clk(clk), .rst(rst), .start(start), .spike_in(spike_in), .busy(busy0), .out_valid(valid0),
    .out_ready(out_ready), .counts(counts0), .winner(win0), .no_spike(ns0));
  spike_rate_decoder #(.NUM_OUTPUTS(N), .WINDOW(WIN), .COUNT_WIDTH(4)) d1 (
    .clk(clk), .rst(rst), .start(start), .spike_in(spike_in), .busy(busy1), .out_valid(valid1),
    .out_ready(out_ready), .counts(counts1), .winner(win1), .no_spike(ns1));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  // Model: elapsed edges since an accepted start, raw spike sums per neuron.
  int sum [N];
  bit running, holding, have;
  int t;
  always @(posedge clk or negedge rst)
    if (!rst) begin
      running = 0; holding = 0; have = 0; t = 0;
      for (int i = 0; i < N; i++) sum[i] = 0;
    end else if (running) begin
      t++;
      if (t <= WIN) for (int i = 0; i < N; i++) sum[i] += int'(spike_in[i]);
      if (t == LAT) begin running = 0; holding = 1; have = 1; end
    end else if (holding) begin
      if (out_ready) holding = 0;
    end else if (start) begin
      running = 1; t = 0;
      for (int i = 0; i < N; i++) sum[i] = 0;
      have = 0;
    end

  function automatic int sat(input int v, input int m);
    return v > m ? m : v;
  endfunction
  function automatic int best(input int m);
    int b = 0;
    for (int i = 1; i < N; i++) if (sat(sum[i], m) > sat(sum[b], m)) b = i;
    return b;
  endfunction
  function automatic bit all_zero();
    for (int i = 0; i < N; i++) if (sum[i] != 0) return 0;
    return 1;
  endfunction

  always @(negedge clk) begin
    logic [31:0] e0;
    logic [15:0] e1;
    for (int i = 0; i < N; i++) begin
      e0[i*8 +: 8] = 8'(sat(sum[i], 255));
      e1[i*4 +: 4] = 4'(sat(sum[i], 15));
    end
    chk("busy0", 32'(busy0), 32'(running));
    chk("valid0", 32'(valid0), 32'(holding));
    chk("counts0", counts0, e0);
    chk("winner0", 32'(win0), (have && ARGM) ? 32'(best(255)) : 32'd0);
    chk("no_spike0", 32'(ns0), 32'(have && all_zero()));
    chk("busy1", 32'(busy1), 32'(running));
    chk("valid1", 32'(valid1), 32'(holding));
    chk("counts1", 32'(counts1), 32'(e1));
    chk("winner1", 32'(win1), (have && ARGM) ? 32'(best(15)) : 32'd0);
    chk("no_spike1", 32'(ns1), 32'(have && all_zero()));
  end

  function automatic logic [N-1:0] pat(input int mode, input int s);
    case (mode)
      0: return 4'b0100;
      1: return 4'b0001;
      2: return (s < 10) ? 4'b1010 : 4'b0000;
      3: return 4'b0000;
      4: return (s % 3 == 0) ? 4'b0011 : ((s % 4 == 1) ? 4'b0100 : 4'b0000);
      default: return ((s % 5 < 2) ? 4'b1000 : 4'b0000) | ((s % 7 == 0) ? 4'b0010 : 4'b0000);
    endcase
  endfunction

  task automatic start_win();
    @(negedge clk);
    start = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    ks = cyc;
  endtask
  task automatic feed(input int mode, input int n);
    for (int s = 0; s < n; s++) begin
      spike_in = pat(mode, s);
      @(negedge clk);
    end
    spike_in = '0;
  endtask
  task automatic wait_valid(input string name);
    int n = 0;
    while (!valid0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_valid_seen"}, 32'(valid0), 32'd1);
    chk({name, "_latency"}, 32'(cyc - ks), 32'(LAT));
  endtask
  task automatic accept();
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("accept_valid_low", 32'(valid0), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic [31:0] snap;
    @(negedge clk);
    chk("reset_counts", counts0, 32'd0);
    chk("reset_busy", 32'(busy0), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    start_win(); feed(0, WIN); wait_valid("single");
    chk("single_counts0", counts0, 32'h0040_0000);
    chk("single_counts1", 32'(counts1), 32'h0000_0F00);
    chk("single_winner", 32'(win0), ARGM ? 32'd2 : 32'd0);
    chk("single_no_spike", 32'(ns0), 32'd0);
    accept();

    start_win(); feed(1, WIN); wait_valid("sat");
    chk("sat_counts0", counts0, 32'h0000_0040);
    chk("sat_counts1", 32'(counts1), 32'h0000_000F);
    chk("sat_winner1", 32'(win1), 32'd0);
    accept();

    start_win(); feed(2, WIN); wait_valid("tie");
    chk("tie_counts0", counts0, 32'h0A00_0A00);
    chk("tie_counts1", 32'(counts1), 32'h0000_A0A0);
    chk("tie_winner", 32'(win0), ARGM ? 32'd1 : 32'd0);
    accept();

    start_win(); feed(3, WIN); wait_valid("silent");
    chk("silent_counts", counts0, 32'd0);
    chk("silent_no_spike", 32'(ns0), 32'd1);
    chk("silent_winner", 32'(win0), 32'd0);
    accept();

    start_win(); feed(4, WIN); wait_valid("stall");
    chk("stall_counts0", counts0, 32'h000B_1616);
    chk("stall_counts1", 32'(counts1), 32'h0000_0BFF);
    chk("stall_winner1", 32'(win1), 32'd0);
    snap = counts0;
    for (int c = 0; c < 20; c++) begin
      start = (c == 5);
      @(negedge clk);
    end
    start = 1'b0;
    chk("stall_counts_stable", counts0, snap);
    chk("stall_valid_high", 32'(valid0), 32'd1);
    out_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    start = 1'b0;
    chk("hs_valid_low", 32'(valid0), 32'd0);
    @(negedge clk);
    chk("hs_start_ignored", 32'(busy0), 32'd0);
    repeat (2) @(negedge clk);

    start_win(); feed(5, 30);
    #1 rst = 1'b0;
    #1;
    chk("async_counts", counts0, 32'd0);
    chk("async_busy", 32'(busy0), 32'd0);
    chk("async_valid", 32'(valid0), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    start_win(); feed(5, WIN); wait_valid("post_rst");
    chk("post_rst_counts0", counts0, 32'h1A00_0A00);
    chk("post_rst_winner", 32'(win0), ARGM ? 32'd3 : 32'd0);
    accept();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
